// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C sensor-configuration sequencer.
// Optional readback verification is enabled by defining I2C_CFG_VERIFY_EN.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
`ifdef I2C_CFG_VERIFY_EN
    , ST_VERIFY
`endif
  } state_t;

  // LUT address value that turns an entry into a wait of <data> ticks
  localparam logic [15:0] DELAY_MARK_DEF = 16'hFFFF;

  // Registers that must not be read back after writing: soft reset
  // and stream enable change sensor state, so a readback is meaningless
  localparam int VERIFY_ADDR_W = 16;
  localparam int VERIFY_SKIP_N = 2;
  localparam logic [VERIFY_SKIP_N-1:0][VERIFY_ADDR_W-1:0] VERIFY_SKIP = {16'h0100, 16'h0103};

  // One LUT entry in its default 16-bit address / 8-bit data layout
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

  function automatic logic is_verify_skip(input logic [VERIFY_ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < VERIFY_SKIP_N; i++) begin
      if (VERIFY_SKIP[i] == addr) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/i2c_cfg_delay_timer.sv
// Delay timer for in-table wait entries: a prescaler of UNIT clocks per
// tick plus a tick counter. Loading a nonzero tick count starts it; o_expire
// is high in the final clock of the final tick, so the wait lasts exactly
// ticks*UNIT clocks after the load edge.
module i2c_cfg_delay_timer #(
  parameter int UNIT  = 50000,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_ticks,
  output logic             o_expire
);

  localparam int PRE_W = (UNIT > 1) ? $clog2(UNIT) : 1;

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_ticks;
  logic             w_tick_end;

  assign w_tick_end = (r_pre == PRE_W'(UNIT - 1));
  assign o_expire   = (r_ticks == CNT_W'(1)) && w_tick_end;

  // Prescaler runs only while ticks remain; each wrap consumes one tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_ticks <= '0;
    end else if (i_load) begin
      r_pre   <= '0;
      r_ticks <= i_ticks;
    end else if (r_ticks != '0) begin
      if (w_tick_end) begin
        r_pre   <= '0;
        r_ticks <= r_ticks - CNT_W'(1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a sensor-configuration LUT and issues one I2C register write per
// entry via a req/ack handshake, with in-table delays, NACK retry and error
// reporting. Define I2C_CFG_VERIFY_EN to read back each written register.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter int                INDEX_W    = 8,
  parameter logic [ADDR_W-1:0] DELAY_MARK = ADDR_W'(DELAY_MARK_DEF),
  parameter int                DELAY_UNIT = 50000,
  parameter int                RETRY_MAX  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [INDEX_W-1:0]       lut_size,
  output logic [INDEX_W-1:0]       lut_index,
  input  logic [ADDR_W+DATA_W-1:0] lut_data,
  output logic                     i2c_req,
  output logic                     i2c_rw,
  output logic [ADDR_W-1:0]        i2c_addr,
  output logic [DATA_W-1:0]        i2c_wdata,
  input  logic                     i2c_ack,
  input  logic                     i2c_nack,
  input  logic [DATA_W-1:0]        i2c_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [INDEX_W-1:0]       err_index
);

  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  state_t               r_state, w_state_nxt;
  logic [INDEX_W-1:0]   r_index, w_index_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [DATA_W-1:0]    r_data, w_data_nxt;
  logic                 r_req, w_req_nxt;
  logic [RETRY_W-1:0]   r_retry, w_retry_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_error, w_error_nxt;
  logic [INDEX_W-1:0]   r_err_index, w_err_index_nxt;

  logic [ADDR_W-1:0]    w_lut_addr;
  logic [DATA_W-1:0]    w_lut_data;
  logic                 w_is_delay;
  logic                 w_timer_load;
  logic                 w_delay_expire;
  logic                 w_retry_left;

  assign w_lut_addr   = lut_data[ADDR_W+DATA_W-1:DATA_W];
  assign w_lut_data   = lut_data[DATA_W-1:0];
  assign w_is_delay   = (w_lut_addr == DELAY_MARK);
  assign w_timer_load = (r_state == ST_FETCH) && w_is_delay;
  assign w_retry_left = (r_retry < RETRY_W'(RETRY_MAX));

`ifdef I2C_CFG_VERIFY_EN
  logic w_skip_verify;
  assign w_skip_verify = is_verify_skip(VERIFY_ADDR_W'(r_addr));
  assign i2c_rw        = (r_state == ST_VERIFY);
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^i2c_rdata;
  assign i2c_rw         = 1'b0;
`endif

  i2c_cfg_delay_timer #(
    .UNIT  (DELAY_UNIT),
    .CNT_W (DATA_W)
  ) u_delay_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_timer_load),
    .i_ticks  (w_lut_data),
    .o_expire (w_delay_expire)
  );

  // Next-state and next-register logic; req drops for one clock after every
  // ack and is re-raised on the first clock of WRITE/VERIFY with req low
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_req_nxt       = r_req;
    w_retry_nxt     = r_retry;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_err_index_nxt = r_err_index;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_done_nxt      = 1'b0;
          w_error_nxt     = 1'b0;
          w_err_index_nxt = '0;
          w_index_nxt     = '0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = (lut_size == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_addr_nxt = w_lut_addr;
        w_data_nxt = w_lut_data;
        if (w_is_delay) begin
          w_state_nxt = (w_lut_data == '0) ? ST_NEXT : ST_DELAY;
        end else begin
          w_retry_nxt = '0;
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!r_req) begin
          w_req_nxt = 1'b1;
        end else if (i2c_ack) begin
          w_req_nxt = 1'b0;
          if (!i2c_nack) begin
`ifdef I2C_CFG_VERIFY_EN
            w_state_nxt = w_skip_verify ? ST_NEXT : ST_VERIFY;
`else
            w_state_nxt = ST_NEXT;
`endif
          end else if (w_retry_left) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end
      end
`ifdef I2C_CFG_VERIFY_EN
      ST_VERIFY: begin
        if (!r_req) begin
          w_req_nxt = 1'b1;
        end else if (i2c_ack) begin
          w_req_nxt = 1'b0;
          if (!i2c_nack && (i2c_rdata == r_data)) begin
            w_state_nxt = ST_NEXT;
          end else if (w_retry_left) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end
      end
`endif
      ST_DELAY: begin
        if (w_delay_expire) w_state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_index == (lut_size - INDEX_W'(1))) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_index_nxt = r_index + INDEX_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      ST_FAIL: begin
        w_error_nxt     = 1'b1;
        w_err_index_nxt = r_index;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any pass in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_req       <= 1'b0;
      r_retry     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_req       <= w_req_nxt;
      r_retry     <= w_retry_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_err_index <= w_err_index_nxt;
    end
  end

  assign lut_index = r_index;
  assign i2c_req   = r_req;
  assign i2c_addr  = r_addr;
  assign i2c_wdata = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_index = r_err_index;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench for i2c_cfg_sequencer: each pass pushes the expected I2C
// transactions (including retries, readbacks and idle gaps) into a queue and
// a behavioural I2C master pops and compares them as the DUT requests.
module tb_i2c_cfg_sequencer;
  import i2c_cfg_pkg::*;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int INDEX_W     = 8;
  localparam int DELAY_UNIT  = 10;
  localparam int RETRY_MAX   = 3;
  localparam int PASS_BUDGET = 3000;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        nack;
    logic        corrupt;
    int          gap;
  } txn_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [INDEX_W-1:0] lutSize = '0;
  logic [INDEX_W-1:0] lutIndex;
  logic [23:0]        lutData;
  logic               i2c_req, i2c_rw;
  logic [15:0]        i2c_addr;
  logic [7:0]         i2c_wdata;
  logic               i2c_ack = 1'b0;
  logic               i2c_nack = 1'b0;
  logic [7:0]         i2c_rdata = '0;
  logic               busy, done, error;
  logic [INDEX_W-1:0] errIndex;

  cfg_entry_t lutMem [0:15];
  int         nackPlan [0:15];
  int         corruptPlan [0:15];

  txn_t expQ [$];
  bit   expDone, expError;
  int   expErrIdx, expLastIdx;

  int compared = 0;
  int mismatched = 0;
  int lowCount = 0;
  bit justAcked = 1'b0;

  always #5 clk = ~clk;

  assign lutData = lutMem[lutIndex[3:0]];

  i2c_cfg_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .INDEX_W    (INDEX_W),
    .DELAY_MARK (16'hFFFF),
    .DELAY_UNIT (DELAY_UNIT),
    .RETRY_MAX  (RETRY_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lut_size  (lutSize),
    .lut_index (lutIndex),
    .lut_data  (lutData),
    .i2c_req   (i2c_req),
    .i2c_rw    (i2c_rw),
    .i2c_addr  (i2c_addr),
    .i2c_wdata (i2c_wdata),
    .i2c_ack   (i2c_ack),
    .i2c_nack  (i2c_nack),
    .i2c_rdata (i2c_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (errIndex)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setEntry(input int i, input logic [15:0] a, input logic [7:0] d);
    lutMem[i] = '{addr: a, data: d};
  endtask

  task automatic clearPlans();
    for (int i = 0; i < 16; i++) begin
      nackPlan[i]    = 0;
      corruptPlan[i] = 0;
    end
  endtask

  task automatic loadLutA();
    setEntry(0, 16'h0103, 8'h01);
    setEntry(1, 16'h3039, 8'h80);
    setEntry(2, 16'h0100, 8'h01);
  endtask

`ifdef I2C_CFG_VERIFY_EN
  function automatic bit tbSkipsVerify(input logic [15:0] a);
    return (a == 16'h0103) || (a == 16'h0100);
  endfunction
`endif

  // Reference model: expected transaction stream and pass outcome
  task automatic buildExpected(input int size);
    int   pending;
    int   fails;
    int   nackLeft;
    int   corruptLeft;
    bit   entryDone;
    txn_t t;
    expQ.delete();
    expDone    = 1'b1;
    expError   = 1'b0;
    expErrIdx  = 0;
    expLastIdx = (size == 0) ? 0 : size - 1;
    pending    = -1;
    for (int i = 0; i < size; i++) begin
      if (lutMem[i].addr == 16'hFFFF) begin
        if (pending >= 0) pending += int'(lutMem[i].data) * DELAY_UNIT + 2;
        continue;
      end
      fails       = 0;
      nackLeft    = nackPlan[i];
      corruptLeft = corruptPlan[i];
      entryDone   = 1'b0;
      while (!entryDone && !expError) begin
        t = '{rw: 1'b0, addr: lutMem[i].addr, data: lutMem[i].data,
              nack: (nackLeft > 0), corrupt: 1'b0, gap: pending};
        expQ.push_back(t);
        pending = 1;
        if (nackLeft > 0) begin
          nackLeft--;
          fails++;
          if (fails > RETRY_MAX) begin
            expError = 1'b1; expDone = 1'b0; expErrIdx = i; expLastIdx = i;
          end
          continue;
        end
`ifdef I2C_CFG_VERIFY_EN
        if (!tbSkipsVerify(lutMem[i].addr)) begin
          t = '{rw: 1'b1, addr: lutMem[i].addr, data: lutMem[i].data,
                nack: 1'b0, corrupt: (corruptLeft > 0), gap: 1};
          expQ.push_back(t);
          if (corruptLeft > 0) begin
            corruptLeft--;
            fails++;
            if (fails > RETRY_MAX) begin
              expError = 1'b1; expDone = 1'b0; expErrIdx = i; expLastIdx = i;
            end
            continue;
          end
        end
`else
        if (corruptLeft < 0) corruptLeft = 0;
`endif
        entryDone = 1'b1;
      end
      if (expError) break;
      pending = 2;
    end
  endtask

  // Behavioural I2C master: compares each request against the scoreboard,
  // holds it for a random latency, then acks with the planned NACK/readback
  always begin : masterModel
    txn_t t;
    bit   haveExp;
    bit   aborted;
    int   lat;
    @(negedge clk);
    i2c_ack  = 1'b0;
    i2c_nack = 1'b0;
    if (!rst_n) begin
      lowCount  = 0;
      justAcked = 1'b0;
    end else if (justAcked) begin
      checkOutput("reqDropAfterAck", {31'b0, i2c_req}, 32'h0);
      justAcked = 1'b0;
      if (!i2c_req) lowCount++;
    end else if (i2c_req) begin
      haveExp = (expQ.size() != 0);
      if (haveExp) begin
        t = expQ.pop_front();
        checkOutput("txnRw", {31'b0, i2c_rw}, {31'b0, t.rw});
        checkOutput("txnAddr", {16'b0, i2c_addr}, {16'b0, t.addr});
        checkOutput("txnData", {24'b0, i2c_wdata}, {24'b0, t.data});
        if (t.gap >= 0) checkOutput("idleGap", lowCount, t.gap);
      end else begin
        checkOutput("unexpectedReq", {31'b0, i2c_req}, 32'h0);
        t = '{rw: 1'b0, addr: i2c_addr, data: i2c_wdata, nack: 1'b0, corrupt: 1'b0, gap: -1};
      end
      lat     = $urandom_range(1, 3);
      aborted = 1'b0;
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        if (!rst_n) begin
          aborted = 1'b1;
          break;
        end
        if (haveExp) begin
          checkOutput("reqHeld", {31'b0, i2c_req}, 32'h1);
          checkOutput("addrStable", {16'b0, i2c_addr}, {16'b0, t.addr});
        end
      end
      lowCount = 0;
      if (!aborted) begin
        i2c_nack  = t.nack;
        i2c_rdata = t.corrupt ? (t.data ^ 8'h5A) : t.data;
        i2c_ack   = 1'b1;
        justAcked = 1'b1;
      end
    end else begin
      lowCount++;
    end
  end

  // One configuration pass: build expectations, pulse start, wait for idle
  task automatic applyStimulus(input string name, input int size, input bit pokeStart, input int expCycles);
    int cycles;
    lutSize = INDEX_W'(size);
    buildExpected(size);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, ":busyAfterStart"}, {31'b0, busy}, 32'h1);
    checkOutput({name, ":doneCleared"}, {31'b0, done}, 32'h0);
    checkOutput({name, ":errorCleared"}, {31'b0, error}, 32'h0);
    cycles = 0;
    if (pokeStart) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles = 5;
    end
    while (busy && cycles < PASS_BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, ":passFinished"}, {31'b0, busy}, 32'h0);
    if (expCycles >= 0) checkOutput({name, ":latency"}, cycles, expCycles);
    @(negedge clk);
    checkOutput({name, ":done"}, {31'b0, done}, {31'b0, expDone});
    checkOutput({name, ":error"}, {31'b0, error}, {31'b0, expError});
    if (expError) checkOutput({name, ":errIndex"}, {24'b0, errIndex}, expErrIdx);
    checkOutput({name, ":lastIndex"}, {24'b0, lutIndex}, expLastIdx);
    checkOutput({name, ":reqIdle"}, {31'b0, i2c_req}, 32'h0);
    checkOutput({name, ":pendingExpected"}, expQ.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int cycles;
    clearPlans();
    for (int i = 0; i < 16; i++) setEntry(i, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("rst:req", {31'b0, i2c_req}, 32'h0);
    checkOutput("rst:rw", {31'b0, i2c_rw}, 32'h0);
    checkOutput("rst:busy", {31'b0, busy}, 32'h0);
    checkOutput("rst:done", {31'b0, done}, 32'h0);
    checkOutput("rst:error", {31'b0, error}, 32'h0);
    checkOutput("rst:index", {24'b0, lutIndex}, 32'h0);
    checkOutput("rst:addr", {16'b0, i2c_addr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clean 3-entry pass with start poked while busy");
    loadLutA();
    applyStimulus("clean", 3, 1'b1, -1);

    $display("[TB] delay entries (2 ticks and 0 ticks)");
    setEntry(0, 16'h0103, 8'h01);
    setEntry(1, 16'hFFFF, 8'h02);
    setEntry(2, 16'h3039, 8'h80);
    setEntry(3, 16'hFFFF, 8'h00);
    setEntry(4, 16'h0100, 8'h01);
    applyStimulus("delay", 5, 1'b0, -1);

    $display("[TB] entry 1 nacked twice then acked");
    loadLutA();
    clearPlans();
    nackPlan[1] = 2;
    applyStimulus("retry", 3, 1'b0, -1);

    $display("[TB] entry 2 nacked beyond retry budget");
    clearPlans();
    setEntry(0, 16'h0103, 8'h01);
    setEntry(1, 16'h3039, 8'h80);
    setEntry(2, 16'h3100, 8'h55);
    setEntry(3, 16'h0100, 8'h01);
    nackPlan[2] = 4;
    applyStimulus("abort", 4, 1'b0, -1);

    $display("[TB] empty LUT");
    clearPlans();
    applyStimulus("empty", 0, 1'b0, 1);

    $display("[TB] reset asserted during entry 1 write");
    loadLutA();
    lutSize = 8'd3;
    buildExpected(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!(i2c_req && lutIndex == 8'd1) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("rstMid:reachedWrite", {31'b0, (i2c_req && lutIndex == 8'd1)}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstMid:req", {31'b0, i2c_req}, 32'h0);
    checkOutput("rstMid:busy", {31'b0, busy}, 32'h0);
    checkOutput("rstMid:index", {24'b0, lutIndex}, 32'h0);
    checkOutput("rstMid:addr", {16'b0, i2c_addr}, 32'h0);
    checkOutput("rstMid:wdata", {24'b0, i2c_wdata}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    expQ.delete();
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("rerun", 3, 1'b0, -1);

`ifdef I2C_CFG_VERIFY_EN
    $display("[TB] readback mismatch on entry 5");
    clearPlans();
    setEntry(0, 16'h0103, 8'h01);
    setEntry(1, 16'h3039, 8'h80);
    setEntry(2, 16'h3040, 8'h11);
    setEntry(3, 16'h3041, 8'h22);
    setEntry(4, 16'h3042, 8'h33);
    setEntry(5, 16'h3050, 8'h44);
    corruptPlan[5] = 1;
    applyStimulus("verify", 6, 1'b0, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
